// File: rtl/ct_key_streamer_pkg.sv
// Shared widths, derived byte counts and FSM states for the ciphertext/key
// streaming stage; also consumed by the encapsulation top and host interface.
package ct_key_streamer_pkg;

  localparam int CIPHERTEXT_BITS = 9104;  // multiple of BYTE_BITS
  localparam int KEY_BITS        = 256;   // multiple of BYTE_BITS
  localparam int BYTE_BITS       = 8;

  localparam int NC    = CIPHERTEXT_BITS / BYTE_BITS;  // 1138 ciphertext bytes
  localparam int NK    = KEY_BITS / BYTE_BITS;         // 32 key bytes
  localparam int CNT_W = $clog2((NC > NK) ? NC : NK);  // 11 bits

  typedef enum logic [1:0] {
    IDLE,
    SEND_C,
    SEND_K,
    FINISH
  } state_t;

endpackage

// File: rtl/ct_key_streamer_byte_shift_reg.sv
// Parallel-load shift register that presents its lowest byte and drops one
// byte per shift, so a wide field drains LSB-first.
module ct_key_streamer_byte_shift_reg
  import ct_key_streamer_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int BYTE_W = BYTE_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [WIDTH-1:0]  d,
  output logic [BYTE_W-1:0] low_byte
);

  logic [WIDTH-1:0] q;

  // Capture has priority; a shift moves the next byte into the low position.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {{BYTE_W{1'b0}}, q[WIDTH-1:BYTE_W]};
    end
  end

  assign low_byte = q[BYTE_W-1:0];

endmodule

// File: rtl/ct_key_streamer.sv
// Captures ciphertext and shared key in one cycle, then streams them as bytes
// over valid/ready: all ciphertext bytes, then all key bytes, then a done pulse.
module ct_key_streamer
  import ct_key_streamer_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [CIPHERTEXT_BITS:1] c_in,
  input  logic [KEY_BITS:1]        k_in,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_BITS-1:0]     out_data,
  output logic                     out_sel,
  output logic                     out_last,
  output logic                     done
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NC - 1);
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(NK - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 hs;
  logic                 cap;
  logic                 c_shift, k_shift;
  logic [BYTE_BITS-1:0] c_byte, k_byte;

  assign hs      = out_valid && out_ready;
  // Loads outside IDLE are dropped so an in-flight transfer is never corrupted.
  assign cap     = (state_q == IDLE) && load;
  assign c_shift = (state_q == SEND_C) && hs;
  assign k_shift = (state_q == SEND_K) && hs;

  ct_key_streamer_byte_shift_reg #(
    .WIDTH (CIPHERTEXT_BITS),
    .BYTE_W(BYTE_BITS)
  ) u_c_sreg (
    .clk     (clk),
    .rst     (rst),
    .load    (cap),
    .shift   (c_shift),
    .d       (c_in),
    .low_byte(c_byte)
  );

  ct_key_streamer_byte_shift_reg #(
    .WIDTH (KEY_BITS),
    .BYTE_W(BYTE_BITS)
  ) u_k_sreg (
    .clk     (clk),
    .rst     (rst),
    .load    (cap),
    .shift   (k_shift),
    .d       (k_in),
    .low_byte(k_byte)
  );

  // State and byte counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: advance the counter per handshake, switch field at its last byte.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SEND_C;
          cnt_d   = '0;
        end
      end
      SEND_C: begin
        if (hs) begin
          if (cnt_q == C_LAST) begin
            state_d = SEND_K;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      SEND_K: begin
        if (hs) begin
          if (cnt_q == K_LAST) begin
            state_d = FINISH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode registered state only, so reset clears them at once and
  // they stay stable across a stall.
  assign out_valid = (state_q == SEND_C) || (state_q == SEND_K);
  assign busy      = out_valid;
  assign out_sel   = (state_q == SEND_K);
  assign out_last  = (state_q == SEND_K) && (cnt_q == K_LAST);
  assign done      = (state_q == FINISH);

  // Byte mux: low byte of whichever field is draining, zero otherwise.
  always_comb begin
    out_data = '0;
    case (state_q)
      SEND_C:  out_data = c_byte;
      SEND_K:  out_data = k_byte;
      default: out_data = '0;
    endcase
  end

endmodule

// File: tb/tb_ct_key_streamer.sv
// Directed bench for ct_key_streamer: reset, full stream, backpressure,
// field-boundary stall, load while busy and reset mid-stream.
module tb_ct_key_streamer;
  import ct_key_streamer_pkg::*;

  localparam int NTOT = NC + NK;  // 1170 bytes per transfer

  logic                     clk;
  logic                     rst;
  logic                     load;
  logic [CIPHERTEXT_BITS:1] c_in;
  logic [KEY_BITS:1]        k_in;
  logic                     busy;
  logic                     out_valid;
  logic                     out_ready;
  logic [BYTE_BITS-1:0]     out_data;
  logic                     out_sel;
  logic                     out_last;
  logic                     done;

  logic [CIPHERTEXT_BITS:1] c_a, c_b;
  logic [KEY_BITS:1]        k_a, k_b;

  int n_pass  = 0;
  int n_total = 0;

  ct_key_streamer dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .c_in     (c_in),
    .k_in     (k_in),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_last (out_last),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end

  // Expected byte stream: ciphertext byte i = i mod 256, key byte j = 0xA0 + j.
  function automatic logic [7:0] exp_data(int i);
    if (i < NC) return 8'(i);
    return 8'(32'hA0 + (i - NC));
  endfunction

  function automatic logic exp_sel(int i);
    return (i >= NC);
  endfunction

  function automatic logic exp_last(int i);
    return (i == NTOT - 1);
  endfunction

  task automatic test_reset();
    rst = 1'b0; load = 1'b0; out_ready = 1'b1; c_in = c_a; k_in = k_a;
    repeat (2) @(negedge clk);
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_total++; if (out_data !== 8'h00) $display("FAIL reset_data: got %h want 00", out_data); else n_pass++;
    n_total++; if (out_sel !== 1'b0 || out_last !== 1'b0) $display("FAIL reset_sel_last: got %b%b want 00", out_sel, out_last); else n_pass++;
    load = 1'b1;
    repeat (2) @(negedge clk);
    n_total++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL reset_load_ignored: valid/busy %b%b want 00", out_valid, busy); else n_pass++;
    load = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    n_total++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) $display("FAIL idle_after_reset: valid/busy/done %b%b%b want 000", out_valid, busy, done); else n_pass++;
  endtask

  task automatic test_full_stream();
    int idx, dones, done_at;
    idx = 0; dones = 0; done_at = -1;
    @(negedge clk); c_in = c_a; k_in = k_a; out_ready = 1'b1; load = 1'b1;
    for (int cyc = 1; cyc <= NTOT + 5; cyc++) begin
      @(negedge clk); load = 1'b0;
      n_total++; if (out_valid !== (idx < NTOT)) $display("FAIL full_valid cyc %0d: got %b want %b", cyc, out_valid, idx < NTOT); else n_pass++;
      n_total++; if (busy !== (idx < NTOT)) $display("FAIL full_busy cyc %0d: got %b want %b", cyc, busy, idx < NTOT); else n_pass++;
      if (out_valid === 1'b1 && idx < NTOT) begin
        n_total++; if (out_data !== exp_data(idx)) $display("FAIL full_data byte %0d: got %h want %h", idx, out_data, exp_data(idx)); else n_pass++;
        n_total++; if (out_sel !== exp_sel(idx)) $display("FAIL full_sel byte %0d: got %b want %b", idx, out_sel, exp_sel(idx)); else n_pass++;
        n_total++; if (out_last !== exp_last(idx)) $display("FAIL full_last byte %0d: got %b want %b", idx, out_last, exp_last(idx)); else n_pass++;
        idx++;
      end
      if (done === 1'b1) begin dones++; done_at = cyc; end
    end
    n_total++; if (idx != NTOT) $display("FAIL full_count: got %0d bytes want %0d", idx, NTOT); else n_pass++;
    n_total++; if (dones != 1) $display("FAIL full_done_count: got %0d want 1", dones); else n_pass++;
    n_total++; if (done_at != NTOT + 1) $display("FAIL full_done_cycle: got %0d want %0d", done_at, NTOT + 1); else n_pass++;
  endtask

  task automatic test_backpressure();
    int idx, hs_cnt, dones, done_at, cyc;
    logic prev_stall;
    logic [7:0] prev_data;
    logic prev_sel, prev_last;
    idx = 0; hs_cnt = 0; dones = 0; done_at = 0; cyc = 0;
    prev_stall = 1'b0; prev_data = '0; prev_sel = 1'b0; prev_last = 1'b0;
    @(negedge clk); c_in = c_a; k_in = k_a; load = 1'b1;
    while (cyc < 6000 && !(dones > 0 && cyc > done_at + 3)) begin
      @(negedge clk); cyc++; load = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      if (prev_stall) begin
        n_total++;
        if (out_valid !== 1'b1 || out_data !== prev_data || out_sel !== prev_sel || out_last !== prev_last)
          $display("FAIL bp_stall_hold byte %0d: got v%b %h s%b l%b want v1 %h s%b l%b", idx, out_valid, out_data, out_sel, out_last, prev_data, prev_sel, prev_last);
        else n_pass++;
      end
      n_total++; if (out_valid !== (idx < NTOT)) $display("FAIL bp_valid byte %0d: got %b want %b", idx, out_valid, idx < NTOT); else n_pass++;
      if (out_valid === 1'b1 && idx < NTOT) begin
        n_total++; if (out_data !== exp_data(idx) || out_sel !== exp_sel(idx) || out_last !== exp_last(idx))
          $display("FAIL bp_byte %0d: got %h s%b l%b want %h s%b l%b", idx, out_data, out_sel, out_last, exp_data(idx), exp_sel(idx), exp_last(idx));
        else n_pass++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data; prev_sel = out_sel; prev_last = out_last;
      if (out_valid === 1'b1 && out_ready) begin
        hs_cnt++;
        if (idx < NTOT) idx++;
      end
      if (done === 1'b1) begin dones++; done_at = cyc; end
    end
    out_ready = 1'b1;
    n_total++; if (hs_cnt != NTOT) $display("FAIL bp_handshakes: got %0d want %0d", hs_cnt, NTOT); else n_pass++;
    n_total++; if (dones != 1) $display("FAIL bp_done_count: got %0d want 1", dones); else n_pass++;
  endtask

  task automatic test_field_boundary();
    int idx, stall_n, dones;
    logic prev_stall;
    logic [7:0] prev_data;
    idx = 0; stall_n = 0; dones = 0; prev_stall = 1'b0; prev_data = '0;
    @(negedge clk); c_in = c_a; k_in = k_a; out_ready = 1'b1; load = 1'b1;
    for (int cyc = 1; cyc <= NTOT + 12; cyc++) begin
      @(negedge clk); load = 1'b0;
      out_ready = !(idx == NC - 1 && stall_n < 5);
      if (prev_stall) begin
        n_total++; if (out_data !== prev_data || out_sel !== 1'b0 || out_valid !== 1'b1)
          $display("FAIL fb_hold: got v%b %h s%b want v1 %h s0", out_valid, out_data, out_sel, prev_data);
        else n_pass++;
      end
      n_total++; if (out_valid !== (idx < NTOT)) $display("FAIL fb_valid byte %0d: got %b want %b", idx, out_valid, idx < NTOT); else n_pass++;
      if (out_valid === 1'b1 && idx < NTOT) begin
        n_total++; if (out_data !== exp_data(idx) || out_sel !== exp_sel(idx) || out_last !== exp_last(idx))
          $display("FAIL fb_byte %0d: got %h s%b l%b want %h s%b l%b", idx, out_data, out_sel, out_last, exp_data(idx), exp_sel(idx), exp_last(idx));
        else n_pass++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      if (out_valid === 1'b1 && !out_ready) stall_n++;
      if (out_valid === 1'b1 && out_ready && idx < NTOT) idx++;
      if (done === 1'b1) dones++;
    end
    out_ready = 1'b1;
    n_total++; if (stall_n != 5) $display("FAIL fb_stall_cycles: got %0d want 5", stall_n); else n_pass++;
    n_total++; if (idx != NTOT || dones != 1) $display("FAIL fb_complete: bytes %0d dones %0d want %0d 1", idx, dones, NTOT); else n_pass++;
  endtask

  task automatic test_load_while_busy();
    int idx, dones;
    idx = 0; dones = 0;
    @(negedge clk); c_in = c_a; k_in = k_a; out_ready = 1'b1; load = 1'b1;
    for (int cyc = 1; cyc <= NTOT + 5; cyc++) begin
      @(negedge clk);
      if (idx == 500) begin load = 1'b1; c_in = c_b; k_in = k_b; end
      else load = 1'b0;
      n_total++; if (busy !== (idx < NTOT)) $display("FAIL lb_busy byte %0d: got %b want %b", idx, busy, idx < NTOT); else n_pass++;
      if (out_valid === 1'b1 && idx < NTOT) begin
        n_total++; if (out_data !== exp_data(idx) || out_sel !== exp_sel(idx) || out_last !== exp_last(idx))
          $display("FAIL lb_byte %0d: got %h s%b l%b want %h s%b l%b", idx, out_data, out_sel, out_last, exp_data(idx), exp_sel(idx), exp_last(idx));
        else n_pass++;
        idx++;
      end
      if (done === 1'b1) dones++;
    end
    load = 1'b0; c_in = c_a; k_in = k_a;
    n_total++; if (idx != NTOT || dones != 1) $display("FAIL lb_complete: bytes %0d dones %0d want %0d 1", idx, dones, NTOT); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int idx, dones;
    bit hit;
    idx = 0; dones = 0; hit = 1'b0;
    @(negedge clk); c_in = c_a; k_in = k_a; out_ready = 1'b1; load = 1'b1;
    for (int cyc = 1; cyc <= NTOT + 5 && !hit; cyc++) begin
      @(negedge clk); load = 1'b0;
      if (out_valid === 1'b1 && idx < NTOT) begin
        if (idx == NC + 10) begin
          n_total++; if (out_data !== exp_data(idx) || out_sel !== 1'b1) $display("FAIL rm_pre_byte: got %h s%b want %h s1", out_data, out_sel, exp_data(idx)); else n_pass++;
          rst = 1'b0;
          #1;
          hit = 1'b1;
        end else begin
          idx++;
        end
      end
      if (done === 1'b1) dones++;
    end
    n_total++; if (!hit) $display("FAIL rm_reach: key byte 10 not reached, got byte %0d want %0d", idx, NC + 10); else n_pass++;
    n_total++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rm_async_drop: valid/busy %b%b want 00", out_valid, busy); else n_pass++;
    n_total++; if (out_data !== 8'h00 || out_sel !== 1'b0 || out_last !== 1'b0) $display("FAIL rm_async_outs: %h s%b l%b want 00 s0 l0", out_data, out_sel, out_last); else n_pass++;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1 || out_last === 1'b1) dones++;
    end
    n_total++; if (dones != 0) $display("FAIL rm_no_done: got %0d done/last pulses want 0", dones); else n_pass++;
    test_full_stream();
  endtask

  initial begin
    for (int i = 0; i < NC; i++) begin
      c_a[8*i+1 +: 8] = 8'(i);
      c_b[8*i+1 +: 8] = 8'(i * 7 + 3);
    end
    for (int j = 0; j < NK; j++) begin
      k_a[8*j+1 +: 8] = 8'(32'hA0 + j);
      k_b[8*j+1 +: 8] = 8'(32'h55 ^ j);
    end
    rst = 1'b0; load = 1'b0; out_ready = 1'b0; c_in = '0; k_in = '0;
    test_reset();
    test_full_stream();
    test_backpressure();
    test_field_boundary();
    test_load_while_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ct_key_streamer.md
Name: ct_key_streamer

Overview:
- Downstream stage of the encapsulation datapath.
- Captures the packed ciphertext c (CIPHERTEXT_BITS) and shared key k (KEY_BITS) in one cycle, then streams them out as bytes over a valid/ready handshake: all ciphertext bytes first, then all key bytes.
- Frees the encapsulation core to restart while the result drains to the host interface.

Parameters:
- CIPHERTEXT_BITS, 9104, packed ciphertext width; must be a multiple of BYTE_BITS.
- KEY_BITS, 256, shared key width; must be a multiple of BYTE_BITS.
- BYTE_BITS, 8, output symbol width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- load  input  1  one-cycle capture strobe for c_in/k_in.
- c_in  input  CIPHERTEXT_BITS  packed ciphertext, bit-indexed [CIPHERTEXT_BITS:1].
- k_in  input  KEY_BITS  shared key, bit-indexed [KEY_BITS:1].
- busy  output  1  high from the cycle after an accepted load until done.
- out_valid  output  1  out_data holds a valid byte.
- out_ready  input  1  consumer accepts the byte on clk when out_valid && out_ready.
- out_data  output  BYTE_BITS  current byte.
- out_sel  output  1  0 = ciphertext byte, 1 = key byte.
- out_last  output  1  high with the final key byte.
- done  output  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset (rst=0, async): state IDLE. busy, out_valid, out_sel, out_last and done = 0. out_data = 0. Shift registers and counter = 0. Outputs drop immediately, without waiting for clk.
- Byte order: LSB-first within each field.
  - Ciphertext byte i = c_in[8i+8 : 8i+1], for i = 0..NC-1, NC = CIPHERTEXT_BITS/8 = 1138.
  - Key byte j = k_in[8j+8 : 8j+1], for j = 0..NK-1, NK = KEY_BITS/8 = 32.
- FSM states: IDLE, SEND_C, SEND_K, FINISH.
- IDLE:
  - load=1 captures c_in and k_in into internal registers, clears the byte counter and moves to SEND_C.
  - out_valid, busy and out_sel=0 are all registered high/valid in the next cycle (latency 1 from load to first byte).
- SEND_C:
  - out_valid=1, out_data = low byte of the ciphertext register.
  - On a handshake the register shifts right by BYTE_BITS and the counter increments.
  - On the handshake with counter = NC-1: counter clears, go to SEND_K, out_sel=1 from the next cycle.
  - No bubble between fields.
- SEND_K:
  - Same shifting rules on the key register.
  - out_last = 1 while counter = NK-1.
  - On that handshake go to FINISH; out_valid, out_last and busy deassert next cycle.
- FINISH: done=1 for exactly one cycle, then IDLE. A load in FINISH is ignored.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_data, out_sel and out_last are held stable.
  - out_valid never drops without a handshake, except on reset.
  - out_ready while out_valid=0 has no effect.
- load while not in IDLE is ignored. Captured data is unaffected and no error is flagged.
- Throughput: 1 byte/cycle with out_ready held high. A full transfer is 1170 handshake cycles, plus 1 cycle load latency, plus 1 FINISH cycle.
- Counter width: clog2(max(NC,NK)) = 11 bits. It never exceeds NC-1; no wrap-around is reachable.
- Reset mid-stream aborts the transfer; no partial done or last is produced.

Decomposition:
- Shared package: CIPHERTEXT_BITS, KEY_BITS, BYTE_BITS, derived NC/NK constants, and the FSM state enum (IDLE, SEND_C, SEND_K, FINISH). These are shared with the upstream encapsulation top and the future host interface.
- One natural sub-module: byte_shift_reg (parameterised width, load/shift/low-byte out), instantiated once for c and once for k.

Test Plan:
- Reset then idle: rst=0 with out_ready=1 -> out_valid=0, busy=0, done=0. load with rst=0 -> no capture.
- Full stream with out_ready=1: c_in byte i = i mod 256, k_in byte j = 0xA0+j.
  - -> 1138 bytes 0x00..0xFF,0x00.. with out_sel=0.
  - -> then 32 bytes 0xA0..0xBF with out_sel=1.
  - -> out_last only on byte 0xBF.
  - -> done pulses exactly 1171 cycles after the load cycle.
- Backpressure: toggle out_ready pseudo-randomly (50%) -> byte sequence identical to the previous test, data stable during every stall, exactly 1170 handshakes, single done.
- Field boundary stall: hold out_ready=0 when counter = NC-1 for 5 cycles -> c byte 1137 held with out_sel=0. First key byte follows the next handshake with no gap.
- Load while busy: second load with different data at byte 500 -> stream continues with the original data, busy stays high, and only one done is produced.
- Reset mid-operation: rst=0 during SEND_K at key byte 10 -> out_valid and busy go low asynchronously, no done. A fresh load afterwards streams correctly from ciphertext byte 0.
